// File: rtl/rr_grant_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package rr_grant_pkg;

  typedef enum logic [1:0] {
    Idle    = 2'h0,
    Grant   = 2'h1,
    Release = 2'h2
  } rr_state_t;

  // Increment with explicit wrap, valid for any modulus (not only powers of two).
  function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_grant_fsm_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr.
module rr_pick
  import rr_grant_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any_c,
  output logic [ID_W-1:0]    win_id_c,
  output logic [NUM_REQ-1:0] win_onehot_c
);

  always_comb begin
    logic [ID_W-1:0] cand;
    any_c        = 1'b0;
    win_id_c     = '0;
    win_onehot_c = '0;
    cand         = ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_c && req[cand]) begin
        any_c              = 1'b1;
        win_id_c           = cand;
        win_onehot_c[cand] = 1'b1;
      end
      cand = ID_W'(mod_inc(32'(cand), NUM_REQ));
    end
  end

endmodule

// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter: one owner at a time, bounded hold, one idle bubble between owners.
module rr_grant_fsm
  import rr_grant_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy
);

  localparam int unsigned HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  rr_state_t           state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [HC_W-1:0]     hold_q, hold_d;
  logic [NUM_REQ-1:0]  gnt_d;
  logic [ID_W-1:0]     gnt_id_d;
  logic                exit_c;
  logic                any_c;
  logic [ID_W-1:0]     win_id_c;
  logic [NUM_REQ-1:0]  win_onehot_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req          (req),
    .ptr          (ptr_q),
    .any_c        (any_c),
    .win_id_c     (win_id_c),
    .win_onehot_c (win_onehot_c)
  );

  // Any single cause ends the grant; coincident causes still give one transition.
  always_comb begin
    exit_c = !req[gnt_id] || done;
    if (MAX_HOLD != 0 && hold_q == HC_W'(MAX_HOLD - 32'd1)) exit_c = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    case (state_q)
      Idle, Release: begin
        if (any_c) begin
          state_d  = Grant;
          gnt_d    = win_onehot_c;
          gnt_id_d = win_id_c;
          hold_d   = '0;
        end else begin
          state_d  = Idle;
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      Grant: begin
        if (exit_c) begin
          state_d  = Release;
          gnt_d    = '0;
          gnt_id_d = '0;
          ptr_d    = ID_W'(mod_inc(32'(gnt_id), NUM_REQ));
        end else if (hold_q != '1) begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: begin
        state_d  = Idle;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  // Outputs are flopped alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= Idle;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_id    <= gnt_id_d;
      gnt_valid <= |gnt_d;
      busy      <= (state_d != Idle);
    end
  end

endmodule
